// File: rtl/reset_mixer.sv
// Reset conditioning for the p1v core: synchronises the push button and the Prop Plug line,
// debounces the button, stretches every reset and records the source of the most recent reset.
module reset_mixer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_600_000,
    parameter int STRETCH_CYCLES  = 8_000_000
) (
    input  logic       clock_160,
    input  logic       res,
    input  logic       key_n,
    input  logic       pin_resn,
    output logic       inp_resn,
    output logic [1:0] res_cause
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

    localparam logic [1:0] HOLD    = 2'b00;
    localparam logic [1:0] STRETCH = 2'b01;
    localparam logic [1:0] RUN     = 2'b10;

    logic [SYNC_STAGES-1:0] key_sync;
    logic [SYNC_STAGES-1:0] plug_sync;
    logic                   key_s;
    logic                   plug_s;
    logic                   btn_stable;
    logic [DB_W-1:0]        db_cnt;
    logic [ST_W-1:0]        st_cnt;
    logic [1:0]             state;
    logic                   src_btn;
    logic                   src_plug;
    logic                   any_src;

    // NOTE: non-blocking assignments let every stage sample its predecessor's old value,
    // so the chain shifts by one flop per edge regardless of statement order.
    always_ff @(posedge clock_160 or posedge res) begin
        if (res) begin
            key_sync  <= '1;
            plug_sync <= '1;
        end else begin
            key_sync  <= {key_sync[SYNC_STAGES-2:0], key_n};
            plug_sync <= {plug_sync[SYNC_STAGES-2:0], pin_resn};
        end
    end

    assign key_s  = key_sync[SYNC_STAGES-1];
    assign plug_s = plug_sync[SYNC_STAGES-1];

    // A new button level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clock_160 or posedge res) begin
        if (res) begin
            btn_stable <= 1'b1;
            db_cnt     <= '0;
        end else if (key_s == btn_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_stable <= key_s;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign src_btn  = ~btn_stable;
    assign src_plug = ~plug_s;
    assign any_src  = src_btn | src_plug;

    // inp_resn is its own flop, set on the edge that enters RUN and cleared on the edge that leaves it.
    always_ff @(posedge clock_160 or posedge res) begin
        if (res) begin
            state     <= HOLD;
            st_cnt    <= '0;
            inp_resn  <= 1'b0;
            res_cause <= 2'b00;
        end else begin
            case (state)
                HOLD: begin
                    if (!any_src) begin
                        state  <= STRETCH;
                        st_cnt <= '0;
                    end
                end
                STRETCH: begin
                    if (any_src) begin
                        state     <= HOLD;
                        res_cause <= {src_plug, src_btn};
                    end else if (st_cnt == ST_LAST) begin
                        state    <= RUN;
                        inp_resn <= 1'b1;
                    end else begin
                        st_cnt <= st_cnt + ST_W'(1);
                    end
                end
                RUN: begin
                    if (any_src) begin
                        state     <= HOLD;
                        inp_resn  <= 1'b0;
                        res_cause <= {src_plug, src_btn};
                    end
                end
                default: begin
                    state    <= HOLD;
                    inp_resn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_mixer.sv
// Directed bench for reset_mixer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8) with an
// expected-value queue filled before each step and drained when the step's output is sampled.
module tb_reset_mixer;

    localparam int S = 2;
    localparam int D = 4;
    localparam int T = 8;

    logic       clock_160 = 1'b0;
    logic       res;
    logic       key_n;
    logic       pin_resn;
    logic       inp_resn;
    logic [1:0] res_cause;

    typedef struct {
        string      tag;
        logic       resn;
        logic [1:0] cause;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    reset_mixer #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .STRETCH_CYCLES (T)
    ) dut (
        .clock_160(clock_160),
        .res      (res),
        .key_n    (key_n),
        .pin_resn (pin_resn),
        .inp_resn (inp_resn),
        .res_cause(res_cause)
    );

    always #5 clock_160 = ~clock_160;

    // Advance n rising edges and settle just past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock_160);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic resn, input logic [1:0] cause);
        exp_t e;
        e.tag   = tag;
        e.resn  = resn;
        e.cause = cause;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert ({inp_resn, res_cause} === {e.resn, e.cause})
        else begin
            miscompares++;
            $error("FAIL %s: observed inp_resn=%b res_cause=%b, expected inp_resn=%b res_cause=%b",
                   e.tag, inp_resn, res_cause, e.resn, e.cause);
        end
    endtask

    initial begin
        res      = 1'b1;
        key_n    = 1'b1;
        pin_resn = 1'b1;

        // Power-on: reset is visible before any clock edge and through res.
        #1;
        push_exp("por_async", 1'b0, 2'b00); check();
        push_exp("por_hold", 1'b0, 2'b00);
        tick(5); check();
        res = 1'b0;
        push_exp("por_edge8", 1'b0, 2'b00);
        tick(T); check();
        push_exp("por_edge9", 1'b1, 2'b00);
        tick(1); check();

        // Prop Plug pulse of one cycle: falls on edge 3, plug_s back high on edge 3, rises on edge 12.
        pin_resn = 1'b0;
        tick(1);
        pin_resn = 1'b1;
        push_exp("plug_edge2", 1'b1, 2'b00);
        tick(1); check();
        push_exp("plug_edge3", 1'b0, 2'b10);
        tick(1); check();
        push_exp("plug_edge11", 1'b0, 2'b10);
        tick(T); check();
        push_exp("plug_edge12", 1'b1, 2'b10);
        tick(1); check();

        // Bouncy button: 2-cycle runs never reach the 4-cycle debounce window.
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            push_exp($sformatf("bounce_lo%0d", i), 1'b1, 2'b10);
            tick(2); check();
            key_n = 1'b1;
            push_exp($sformatf("bounce_hi%0d", i), 1'b1, 2'b10);
            tick(2); check();
        end
        push_exp("bounce_settle", 1'b1, 2'b10);
        tick(10); check();

        // Clean press: falls on edge S+D+1 = 7; release rises S+D+1+T = 15 edges later.
        key_n = 1'b0;
        push_exp("btn_edge6", 1'b1, 2'b10);
        tick(S + D); check();
        push_exp("btn_edge7", 1'b0, 2'b01);
        tick(1); check();
        push_exp("btn_held", 1'b0, 2'b01);
        tick(30 - (S + D + 1)); check();
        key_n = 1'b1;
        push_exp("btn_rel14", 1'b0, 2'b01);
        tick(S + D + T); check();
        push_exp("btn_rel15", 1'b1, 2'b01);
        tick(1); check();

        // Abort: second plug pulse 4 cycles into STRETCH forces HOLD; full stretch after it.
        pin_resn = 1'b0;
        tick(1);
        pin_resn = 1'b1;
        push_exp("abort_first", 1'b0, 2'b10);
        tick(7); check();
        pin_resn = 1'b0;
        tick(1);
        pin_resn = 1'b1;
        push_exp("abort_e2", 1'b0, 2'b10);
        tick(1); check();
        push_exp("abort_e4", 1'b0, 2'b10);
        tick(2); check();
        push_exp("abort_e11", 1'b0, 2'b10);
        tick(T - 1); check();
        push_exp("abort_e12", 1'b1, 2'b10);
        tick(1); check();

        // Both sources reach the FSM on the same edge: cause 11, held while the mix changes.
        key_n = 1'b0;
        tick(D);
        pin_resn = 1'b0;
        push_exp("both_edge6", 1'b1, 2'b10);
        tick(S); check();
        push_exp("both_edge7", 1'b0, 2'b11);
        tick(1); check();
        pin_resn = 1'b1;
        push_exp("both_plug_rel", 1'b0, 2'b11);
        tick(4); check();
        key_n = 1'b1;
        push_exp("both_stretch", 1'b0, 2'b11);
        tick(S + D + 1 + 2); check();

        // res mid-stretch clears everything asynchronously; power-on sequence repeats.
        #2;
        res = 1'b1;
        #1;
        push_exp("midres_async", 1'b0, 2'b00); check();
        tick(3);
        res = 1'b0;
        push_exp("midres_edge8", 1'b0, 2'b00);
        tick(T); check();
        push_exp("midres_edge9", 1'b1, 2'b00);
        tick(1); check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
